// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: RV32I multicycle FSM controller driving datapath selects and enables
module multicycle_control_unit #(
  parameter int MEM_LAT = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  output logic       pcwrite_o,
  output logic       adrsrc_o,
  output logic       memwrite_o,
  output logic       irwrite_o,
  output logic       regwrite_o,
  output logic [1:0] resultsrc_o,
  output logic [1:0] alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic [1:0] immsrc_o,
  output logic [2:0] alucontrol_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);
  localparam int CW = $clog2(MEM_LAT) + 1;
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4, MEMWRITE = 4'd5,
    EXECR = 4'd6, ALUWB = 4'd7, EXECI = 4'd8, JAL = 4'd9, BEQ = 4'd10
  } state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic last;
  logic [1:0] aluop;
  assign last = cnt_q == CW'(MEM_LAT - 1);
  assign state_o = state_q;
  assign cnt_d = (rst_i || state_d != state_q || !(state_q == FETCH || state_q == MEMREAD)) ? '0 : cnt_q + CW'(1);
  assign immsrc_o = op_i == 7'b0100011 ? 2'b01 :
                    op_i == 7'b1100011 ? 2'b10 :
                    op_i == 7'b1101111 ? 2'b11 : 2'b00;
  assign alucontrol_o = aluop == 2'b00 ? 3'b000 :
                        aluop == 2'b01 ? 3'b001 :
                        funct3_i == 3'b000 ? {2'b00, op_i[5] & funct7b5_i} :
                        funct3_i == 3'b010 ? 3'b101 :
                        funct3_i == 3'b110 ? 3'b011 :
                        funct3_i == 3'b111 ? 3'b010 : 3'b000;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    {pcwrite_o, adrsrc_o, memwrite_o, irwrite_o, regwrite_o, illegal_o} = '0;
    resultsrc_o = 2'b00;
    alusrca_o = 2'b00;
    alusrcb_o = 2'b00;
    aluop = 2'b00;
    case (state_q)
      FETCH: begin
        state_d = last ? DECODE : FETCH;
        alusrcb_o = 2'b10;
        resultsrc_o = 2'b10;
        irwrite_o = last;
        pcwrite_o = last;
      end
      DECODE: begin
        alusrca_o = 2'b01;
        alusrcb_o = 2'b01;
        case (op_i)
          7'b0000011, 7'b0100011: state_d = MEMADR;
          7'b0110011: state_d = EXECR;
          7'b0010011: state_d = EXECI;
          7'b1101111: state_d = JAL;
          7'b1100011: state_d = BEQ;
          default: begin
            state_d = FETCH;
            illegal_o = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        state_d = op_i[5] ? MEMWRITE : MEMREAD;
        alusrca_o = 2'b10;
        alusrcb_o = 2'b01;
      end
      MEMREAD: begin
        state_d = last ? MEMWB : MEMREAD;
        adrsrc_o = 1'b1;
      end
      MEMWB: begin
        state_d = FETCH;
        resultsrc_o = 2'b01;
        regwrite_o = 1'b1;
      end
      MEMWRITE: begin
        state_d = FETCH;
        adrsrc_o = 1'b1;
        memwrite_o = 1'b1;
      end
      EXECR: begin
        state_d = ALUWB;
        alusrca_o = 2'b10;
        aluop = 2'b10;
      end
      EXECI: begin
        state_d = ALUWB;
        alusrca_o = 2'b10;
        alusrcb_o = 2'b01;
        aluop = 2'b10;
      end
      ALUWB: begin
        state_d = FETCH;
        regwrite_o = 1'b1;
      end
      JAL: begin
        state_d = ALUWB;
        alusrca_o = 2'b01;
        alusrcb_o = 2'b10;
        pcwrite_o = 1'b1;
      end
      BEQ: begin
        state_d = FETCH;
        alusrca_o = 2'b10;
        aluop = 2'b01;
        pcwrite_o = zero_i;
      end
      default: state_d = FETCH;
    endcase
    if (rst_i) begin
      state_d = FETCH;
      {pcwrite_o, adrsrc_o, memwrite_o, irwrite_o, regwrite_o, illegal_o} = '0;
      resultsrc_o = 2'b10;
      alusrca_o = 2'b00;
      alusrcb_o = 2'b10;
      aluop = 2'b00;
    end
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: scoreboard bench of the controller with MEM_LAT=3
module tb_multicycle_control_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] op = 7'b0110011;
  logic [2:0] f3 = 3'b000;
  logic f7 = 1'b0;
  logic z = 1'b0;
  logic pcw, adr, mw, irw, rw, ill;
  logic [1:0] rs, sa, sb, im;
  logic [2:0] ac;
  logic [3:0] st;
  logic [20:0] got;
  typedef struct {
    logic [20:0] v;
    string nm;
  } exp_t;
  exp_t q[$];
  int n = 0;
  int errs = 0;
  multicycle_control_unit #(.MEM_LAT(3)) dut (
    .clk_i(clk), .rst_i(rst), .op_i(op), .funct3_i(f3), .funct7b5_i(f7), .zero_i(z),
    .pcwrite_o(pcw), .adrsrc_o(adr), .memwrite_o(mw), .irwrite_o(irw), .regwrite_o(rw),
    .resultsrc_o(rs), .alusrca_o(sa), .alusrcb_o(sb), .immsrc_o(im), .alucontrol_o(ac),
    .illegal_o(ill), .state_o(st)
  );
  always #5 clk = ~clk;
  assign got = {st, pcw, adr, mw, irw, rw, rs, sa, sb, im, ac, ill};
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n++;
      if (got !== e.v) begin
        errs++;
        $display("FAIL %s: got st=%0d pcw=%b adr=%b mw=%b irw=%b rw=%b rs=%b sa=%b sb=%b im=%b ac=%b ill=%b, want %h got %h",
                 e.nm, st, pcw, adr, mw, irw, rw, rs, sa, sb, im, ac, ill, e.v, got);
      end
    end
  end
  function automatic logic [20:0] ex(input logic [3:0] s, input logic p, a, m, i, r,
                                     input logic [1:0] res, sra, srb, imm, input logic [2:0] alu, input logic il);
    return {s, p, a, m, i, r, res, sra, srb, imm, alu, il};
  endfunction
  task automatic set_in(input logic [6:0] o, input logic [2:0] f, input logic f7v, input logic zv);
    op = o;
    f3 = f;
    f7 = f7v;
    z = zv;
  endtask
  task automatic step(input logic [20:0] v, input string nm);
    q.push_back('{v, nm});
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [1:0] imm, input string nm);
    step(ex(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0), {nm, "_fetch0"});
    step(ex(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0), {nm, "_fetch1"});
    step(ex(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0), {nm, "_fetch2"});
  endtask
  task automatic decode(input logic [1:0] imm, input string nm);
    step(ex(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0), {nm, "_decode"});
  endtask
  task automatic aluwb(input logic [1:0] imm, input string nm);
    step(ex(7, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0), {nm, "_aluwb"});
  endtask
  task automatic rtype(input logic [2:0] f, input logic f7v, input logic [2:0] want, input string nm);
    set_in(7'b0110011, f, f7v, 0);
    fetch(2'b00, nm);
    decode(2'b00, nm);
    step(ex(6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, want, 0), {nm, "_execr"});
    aluwb(2'b00, nm);
  endtask
  task automatic beq(input logic zv, input string nm);
    set_in(7'b1100011, 3'b000, 0, zv);
    fetch(2'b10, nm);
    decode(2'b10, nm);
    step(ex(10, zv, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0), {nm, "_beq"});
  endtask
  initial begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      step(ex(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0), "reset");
    rst = 1'b0;
    set_in(7'b0000011, 3'b010, 0, 0);
    fetch(2'b00, "lw");
    decode(2'b00, "lw");
    step(ex(2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0), "lw_memadr");
    for (int i = 0; i < 3; i++)
      step(ex(3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), "lw_memread");
    step(ex(4, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0), "lw_memwb");
    set_in(7'b0100011, 3'b010, 0, 0);
    fetch(2'b01, "sw");
    decode(2'b01, "sw");
    step(ex(2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0), "sw_memadr");
    step(ex(5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0), "sw_memwrite");
    rtype(3'b000, 1, 3'b001, "sub");
    rtype(3'b000, 0, 3'b000, "add");
    rtype(3'b010, 0, 3'b101, "slt");
    rtype(3'b110, 0, 3'b011, "or");
    rtype(3'b111, 0, 3'b010, "and");
    set_in(7'b0010011, 3'b000, 1, 0);
    fetch(2'b00, "addi");
    decode(2'b00, "addi");
    step(ex(8, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0), "addi_execi");
    aluwb(2'b00, "addi");
    beq(1, "beq_taken");
    beq(0, "beq_nottaken");
    set_in(7'b1101111, 3'b000, 0, 0);
    fetch(2'b11, "jal");
    decode(2'b11, "jal");
    step(ex(9, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0), "jal_jal");
    aluwb(2'b11, "jal");
    set_in(7'b1111111, 3'b000, 0, 0);
    fetch(2'b00, "illegal");
    step(ex(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1), "illegal_decode");
    set_in(7'b0000011, 3'b010, 0, 0);
    fetch(2'b00, "abort");
    decode(2'b00, "abort");
    step(ex(2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0), "abort_memadr");
    step(ex(3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), "abort_memread");
    rst = 1'b1;
    step(ex(3, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0), "abort_rst");
    rst = 1'b0;
    fetch(2'b00, "abort_after");
    decode(2'b00, "abort_after");
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errs++;
      $display("FAIL drain: %0d expected vectors never checked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
